// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: ALU operation codes and sequencer state encoding
package alu_mul_seq_pkg;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SLT = 2'd2;
    localparam logic [1:0] ALU_SLL = 2'd3;
    typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 8x8 truncated multiply sequenced over the shared ALU
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int W = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         result_zero,
    output logic [1:0]   alu_ctl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_out
);
    localparam int IW = $clog2(W);

    state_t state, state_nxt;
    logic [W-1:0] mplr, mcand, acc, tmp, acc_nxt;
    logic [IW-1:0] idx;
    logic last, rest_zero;

    assign last = idx == IW'(W - 1);
    assign rest_zero = (mplr >> idx) == '0;
    assign ready = state == IDLE;
    assign done = state == DONE;
    assign acc_nxt = state == ADD ? alu_out : acc;

    always_comb begin
        state_nxt = state;
        alu_ctl = ALU_ADD;
        alu_a = '0;
        alu_b = '0;
        case (state)
            IDLE: state_nxt = start ? SHIFT : IDLE;
            SHIFT: begin
                if (mplr[idx]) begin
                    alu_ctl = ALU_SLL;
                    alu_a = W'(idx);
                    alu_b = mcand;
                end
                if (abort) state_nxt = IDLE;
                else if (EARLY_EXIT && rest_zero) state_nxt = DONE;
                else if (mplr[idx]) state_nxt = ADD;
                else if (last) state_nxt = DONE;
            end
            ADD: begin
                alu_a = acc;
                alu_b = tmp;
                state_nxt = abort ? IDLE : last ? DONE : SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mplr <= '0;
            mcand <= '0;
            acc <= '0;
            tmp <= '0;
            idx <= '0;
            result <= '0;
            result_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mplr <= opa;
                mcand <= opb;
                acc <= '0;
                idx <= '0;
            end
            if (state == SHIFT && state_nxt == ADD) tmp <= alu_out;
            if (state == ADD) acc <= alu_out;
            if (state != IDLE && state_nxt == SHIFT) idx <= idx + 1'b1;
            // the final ADD's sum lands in result at the same edge it lands in acc
            if (state_nxt == DONE) begin
                result <= acc_nxt;
                result_zero <= acc_nxt == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: two sequencers (early exit on/off) each driving a behavioural ALU
module tb_alu_mul_seq;
    logic clk = 0, rst_n = 0, abort = 0;
    logic [1:0] start = '0;
    logic [7:0] opa = '0, opb = '0;
    logic ready [2], done [2], rz [2];
    logic [7:0] res [2], aa [2], ab [2], ao [2];
    logic [1:0] actl [2];
    int n_chk = 0, n_fail = 0;
    int ctl_q[$], a_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return {7'b0, a < b};
            default: return b << a[3:0];
        endcase
    endfunction

    assign ao[0] = alu_f(actl[0], aa[0], ab[0]);
    assign ao[1] = alu_f(actl[1], aa[1], ab[1]);

    alu_mul_seq #(.W(8), .EARLY_EXIT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .opa(opa), .opb(opb),
        .ready(ready[0]), .done(done[0]), .result(res[0]), .result_zero(rz[0]),
        .alu_ctl(actl[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_out(ao[0]));

    alu_mul_seq #(.W(8), .EARLY_EXIT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .opa(opa), .opb(opb),
        .ready(ready[1]), .done(done[1]), .result(res[1]), .result_zero(rz[1]),
        .alu_ctl(actl[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_out(ao[1]));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_busy(input logic [7:0] a, input bit ee);
        int h = -1;
        for (int i = 0; i < 8; i++) if (a[i]) h = i;
        if (!ee) return 8 + $countones(a);
        if (h < 0) return 1;
        return h + 1 + $countones(a) + (h < 7 ? 1 : 0);
    endfunction

    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input bit hold,
                          output int busy, output int r, output int z);
        int n = 0;
        @(negedge clk);
        opa = a; opb = b; start[sel] = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin opa = ~a; opb = ~b; end else start[sel] = 1'b0;
        ctl_q.delete(); a_q.delete();
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done[sel]) break;
            ctl_q.push_back(int'(actl[sel]));
            a_q.push_back(int'(aa[sel]));
            if (n == 1) check("ready_low", int'(ready[sel]), 0);
        end
        start[sel] = 1'b0;
        check("done_seen", int'(done[sel]), 1);
        busy = n - 1; r = int'(res[sel]); z = int'(rz[sel]);
        @(negedge clk);
        check("ready_back", int'(ready[sel]), 1);
        check("done_pulse", int'(done[sel]), 0);
    endtask

    typedef struct { logic [7:0] a, b, res; bit z; int b0, b1; } vec_t;

    initial begin
        vec_t v [6];
        int busy, r, z, nd;
        logic [7:0] a, b;
        v[0] = '{8'd3, 8'd5, 8'd15, 1'b0, 5, 10};
        v[1] = '{8'h00, 8'hAB, 8'h00, 1'b1, 1, 8};
        v[2] = '{8'hFF, 8'hFF, 8'h01, 1'b0, 16, 16};
        v[3] = '{8'h80, 8'h02, 8'h00, 1'b1, 9, 9};
        v[4] = '{8'h01, 8'hFF, 8'hFF, 1'b0, 3, 9};
        v[5] = '{8'h10, 8'h10, 8'h00, 1'b1, 7, 9};

        #12;
        check("rst_ready", int'(ready[0]), 1);
        check("rst_done", int'(done[0]), 0);
        check("rst_result", int'(res[0]), 0);
        check("rst_rzero", int'(rz[0]), 1);
        check("rst_alu_ctl", int'(actl[0]), 0);
        check("rst_alu_a", int'(aa[0]), 0);
        check("rst_alu_b", int'(ab[0]), 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 2; s++) begin
                run_op(s, v[i].a, v[i].b, 1'b0, busy, r, z);
                check($sformatf("vec%0d_u%0d_result", i, s), r, int'(v[i].res));
                check($sformatf("vec%0d_u%0d_rzero", i, s), z, int'(v[i].z));
                check($sformatf("vec%0d_u%0d_busy", i, s), busy, s == 0 ? v[i].b0 : v[i].b1);
            end
        end

        run_op(0, 8'hFF, 8'hFF, 1'b0, busy, r, z);
        for (int i = 0; i < 16 && i < ctl_q.size(); i++) begin
            check($sformatf("ff_ctl%0d", i), ctl_q[i], i % 2 == 0 ? 3 : 0);
            if (i % 2 == 0) check($sformatf("ff_alu_a%0d", i), a_q[i], i / 2);
        end

        run_op(0, 8'd3, 8'd5, 1'b1, busy, r, z);
        check("hold_result", r, 15);
        check("hold_busy", busy, 5);

        @(negedge clk); opa = 8'd3; opb = 8'd5; start[0] = 1'b1;
        @(posedge clk); #1; opa = 8'hFF; opb = 8'hFF;
        @(negedge clk); check("abort_busy1", int'(ready[0]), 0);
        @(negedge clk); abort = 1'b1; start[0] = 1'b0;
        @(negedge clk); abort = 1'b0;
        check("abort_ready", int'(ready[0]), 1);
        check("abort_result", int'(res[0]), 15);
        nd = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); nd += int'(done[0]); end
        check("abort_no_done", nd, 0);
        run_op(0, 8'd7, 8'd9, 1'b0, busy, r, z);
        check("post_abort_result", r, 63);

        @(negedge clk); opa = 8'hFF; opb = 8'hFF; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shift_ctl", int'(actl[0]), 3);
        rst_n = 0; #1;
        check("mrst_ready", int'(ready[0]), 1);
        check("mrst_done", int'(done[0]), 0);
        check("mrst_result", int'(res[0]), 0);
        check("mrst_rzero", int'(rz[0]), 1);
        check("mrst_alu_ctl", int'(actl[0]), 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 40; i++) begin
            int s;
            s = i % 2;
            a = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFF : 8'h0F);
            b = 8'($urandom);
            run_op(s, a, b, 1'b0, busy, r, z);
            check($sformatf("rnd%0d_result", i), r, int'(8'(a * b)));
            check($sformatf("rnd%0d_rzero", i), z, 8'(a * b) == 0 ? 1 : 0);
            check($sformatf("rnd%0d_busy", i), busy, ref_busy(a, s == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes an unsigned 8x8 multiply, truncated to the low 8 bits, by driving the shared 8-bit combinational ALU through its shift-left (ctl 3) and add (ctl 0) operations. It sits between the control unit and the ALU's operand and control inputs. It accepts one request at a time over a start/ready handshake and reports completion with a one-cycle `done` pulse.

## Interface
- `W`, 8: datapath width. It must equal the ALU width. `W` ≤ 16, because the shift amount is taken from `alu_a[3:0]`.
- `EARLY_EXIT`, 1: when 1, the block finishes as soon as the remaining multiplier bits are all zero. When 0, it always scans all W bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `abort`  in  1  cancels an operation in progress.
- `opa`  in  W  multiplier, captured on accept.
- `opb`  in  W  multiplicand, captured on accept.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  W  product mod 2^W; held until the next accept.
- `result_zero`  out  1  high when `result`==0; held with `result`.
- `alu_ctl`  out  2  ALU operation select.
- `alu_a`  out  W  ALU operand A.
- `alu_b`  out  W  ALU operand B.
- `alu_out`  in  W  combinational ALU result, valid in the same cycle.

## Operation
- Internal registers:
  - `mplr`: captured opa.
  - `mcand`: captured opb.
  - `acc`.
  - `tmp`: latched shift result.
  - `idx`: bit index, log2(W) bits.
- FSM states: IDLE, SHIFT, ADD, DONE.
- IDLE:
  - `ready`=1.
  - When `start`=1: capture opa/opb, set acc=0 and idx=0, go to SHIFT.
- SHIFT at index idx:
  - If EARLY_EXIT and mplr>>idx == 0: go to DONE.
  - Else if mplr[idx]=1: drive `alu_ctl`=3, `alu_a`=idx, `alu_b`=mcand; latch tmp←alu_out; go to ADD.
  - Else if idx==W-1: go to DONE.
  - Else: idx←idx+1 and stay in SHIFT.
- ADD:
  - Drive `alu_ctl`=0, `alu_a`=acc, `alu_b`=tmp; latch acc←alu_out.
  - If idx==W-1: go to DONE.
  - Else: idx←idx+1 and go to SHIFT.
- DONE:
  - `done`=1.
  - `result`←acc and `result_zero`←(acc==0) are registered on the transition into DONE, so both are visible while `done`=1.
  - Go to IDLE.
- Outside SHIFT and ADD: `alu_ctl`=0 and `alu_a`=`alu_b`=0.
- Arithmetic is mod 2^W; bits shifted out are lost. No overflow flag.
- `abort`:
  - In SHIFT or ADD: go to IDLE next cycle; no `done`; `result` is unchanged.
  - Ignored in IDLE and DONE.
  - `abort` takes priority over all other transitions.
- `start` while busy is ignored and is not queued.

## Timing
- Reset values:
  - state=IDLE, `ready`=1, `done`=0.
  - `result`=0, `result_zero`=1.
  - `alu_ctl`=0, `alu_a`=`alu_b`=0.
  - All internal registers = 0.
- Reset mid-operation: immediate return to IDLE; no `done`.
- Accept edge: the clock edge where `start`=1 and `ready`=1. `ready` falls in the following cycle.
- Latency from the accept edge to `done`, with EARLY_EXIT=1 and h = index of highest set bit of opa:
  - opa≠0: (h+1) SHIFT cycles + popcount(opa) ADD cycles, plus 1 final SHIFT cycle if h<W-1. `done` is in the next cycle.
  - opa=0: 1 SHIFT cycle, then DONE.
- Latency with EARLY_EXIT=0: W + popcount(opa) cycles, then DONE.
- `ready` returns to 1 in the cycle after `done`. Back-to-back requests are separated by at least one IDLE cycle.
- ALU outputs are combinational from state/idx/registers; the ALU's result is sampled at the same edge.

## Structure
- Shared package holds:
  - ALU op constants: ALU_ADD=0, ALU_SUB=1, ALU_SLT=2, ALU_SLL=3.
  - The FSM state enum.
- The ALU is external and shared; the block instantiates no sub-module.
- A thin wrapper pairing this block with one ALU instance, `alu_mul_unit`, is the natural test harness.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT → `ready`=1, `done`=0, `result`=0, `result_zero`=1, `alu_ctl`=0.
- opa=3, opb=5 (EARLY_EXIT=1) → cycles SHIFT,ADD,SHIFT,ADD,SHIFT; `done` in 6th cycle after accept; `result`=15, `result_zero`=0.
- opa=0, opb=0xAB → `done` in 2nd cycle after accept; `result`=0, `result_zero`=1.
- opa=0xFF, opb=0xFF → `result`=0x01 (mod 256); 16 busy cycles; `alu_ctl` alternates 3/0 with `alu_a`=0..7 in SHIFT.
- opa=0x80, opb=2 → `result`=0, `result_zero`=1; 8 SHIFT + 1 ADD; EARLY_EXIT=0 gives the same count.
- `abort` in 2nd busy cycle of opa=3, opb=5 after a prior result of 15 → no `done`, `result` stays 15, `ready`=1 next cycle; `start` held during busy is ignored.
